fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of `memory` on its instruction port. It holds the program counter, issues `i_read`/`i_addr`, and asserts `i_push` one cycle later to latch the word `memory` drives onto `d_bus`. It presents one instruction at a time to decode through a valid/ready handshake, and accepts PC redirects from execute. The data side has priority, so fetch yields whenever the data side is using `memory`.

## Interface

Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `d_active`  in  1  data side asserts `d_read`, `d_write` or `d_push` this cycle.
- `d_bus`  in  16  shared bus, sampled only while `i_push`=1.
- `i_read`  out  1  instruction read request to `memory`.
- `i_push`  out  1  `memory` drives its read word onto `d_bus`.
- `i_addr`  out  16  instruction address (the current PC).
- `redirect`  in  1  branch or jump taken; flush and reload the PC.
- `redirect_addr`  in  16  new PC when `redirect`=1.
- `inst_valid`  out  1  `inst` holds an unconsumed instruction.
- `inst_ready`  in  1  decode accepts `inst` this cycle.
- `inst`  out  16  fetched instruction word.
- `inst_pc`  out  16  address from which `inst` was fetched.

## Operation

State machine with two states, FETCH and CAPTURE. There is one registered output slot (`inst`, `inst_pc`, `inst_valid`).

- `slot_free` = !`inst_valid` || `inst_ready`.
- FETCH:
  - `i_read` = !`d_active` && !`redirect` && `slot_free` (combinational).
  - When `i_read`=1, go to CAPTURE. Otherwise stay in FETCH.
- CAPTURE:
  - `i_push` = !`redirect` (combinational).
  - If `i_push`=1 at the edge: `inst`<=`d_bus`, `inst_pc`<=PC, `inst_valid`<=1, PC<=PC+1.
  - Always return to FETCH.
- `i_addr` = PC at all times.
- Handshake:
  - `inst_valid`&&`inst_ready` at an edge consumes the slot.
  - `inst_valid` clears unless a new word is captured on the same edge; a capture overwrites the slot in the same cycle.
  - `inst`/`inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
- Redirect (any state, highest priority):
  - PC<=`redirect_addr`, `inst_valid`<=0, state<=FETCH.
  - `i_read` and `i_push` are 0 that cycle. A read in flight is abandoned; the `m_store` contents are simply never pushed.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000. `memory` decodes only the low 8 bits, so addresses alias every 256 words; fetch does not check this.
- `d_active`=1 during CAPTURE has no effect on fetch. The data side cannot push in that cycle because it could not have read in the preceding one.

## Timing

- Reset values:
  - State FETCH, PC=`RESET_PC`, `inst_valid`=0, `inst`=16'h0000, `inst_pc`=16'h0000.
  - `i_read`=0 and `i_push`=0 while `rst_n`=0.
- Reset asserted mid-operation (including during CAPTURE) forces all of the above immediately and drops `i_push`.
- Latency:
  - `i_read` in cycle N, `i_push` and capture in cycle N+1, `inst_valid`=1 from cycle N+2.
- Throughput: at most one instruction per two cycles, achieved when `inst_ready` is held high and `d_active`=0.
- First `i_read` occurs in the first cycle after `rst_n` deasserts, provided `d_active`=0.
- `redirect` in cycle N: the first `i_read` to `redirect_addr` occurs no earlier than N+1.
- Simultaneous `redirect` and `inst_ready`: the flush wins. The slot is empty after the edge.

## Structure

- Shared package `cpu_pkg`:
  - `WORD_W`=16.
  - `fetch_state_t` enum {FETCH, CAPTURE}.
  - `RESET_PC` default constant.
- No sub-module. PC register, state register and output slot live in a single always block with asynchronous reset. `i_read`/`i_push` are continuous assigns.

## Test plan

- Reset and stream: preload the memory model with 16'h1111, 16'h2222, 16'h3333 at addresses 0..2; `inst_ready`=1, `d_active`=0.
  - Required: `inst`=1111/2222/3333 with `inst_pc`=0/1/2, `inst_valid` pulsing every 2 cycles, first valid 2 cycles after release.
- Backpressure: hold `inst_ready`=0 after the first valid.
  - Required: `inst` stays 16'h1111, `i_read` stays 0.
  - Release: the next `i_read` occurs in the same cycle that `inst_ready`=1.
- Data priority: hold `d_active`=1 for 3 cycles while in FETCH.
  - Required: `i_read`=0 for those 3 cycles, then `i_read`=1 with `i_addr` unchanged.
- Redirect during CAPTURE: issue `i_read` at PC=5, then assert `redirect` with `redirect_addr`=16'h0010 in the push cycle.
  - Required: `i_push`=0 and no `inst_valid`.
  - Next: `i_read` with `i_addr`=16'h0010, then `inst_pc`=16'h0010.
- Wrap: set `RESET_PC`=16'hFFFF.
  - Required: `inst_pc`=16'hFFFF, then the next `i_addr`=16'h0000.
- Reset mid-CAPTURE: pull `rst_n` low during the `i_push` cycle.
  - Required: `i_push` drops immediately, `inst_valid`=0, PC=`RESET_PC` after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding, reset PC.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    CAPTURE = 1'b1
  } fetch_state_t;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads memory over the shared bus when
// the data side is idle, and hands one word at a time to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_active,
  input  logic [WORD_W-1:0] d_bus,
  output logic              i_read,
  output logic              i_push,
  output logic [WORD_W-1:0] i_addr,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] inst_pc
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic              slot_free;

  // Slot can take a new word if empty or being drained on this edge.
  assign slot_free = !inst_valid || inst_ready;

  // Request a read only when memory is ours and the result has somewhere to go.
  assign i_read = rst_n && (state == FETCH) && !d_active && !redirect && slot_free;

  // Latch the word read last cycle unless a redirect abandons it.
  assign i_push = rst_n && (state == CAPTURE) && !redirect;

  assign i_addr = pc;

  // PC, FSM state and output slot; redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (redirect) begin
      state      <= FETCH;
      pc         <= redirect_addr;
      inst_valid <= 1'b0;
    end else begin
      if (i_push) begin
        inst       <= d_bus;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
        pc         <= pc + WORD_W'(1);
      end else if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end
      case (state)
        FETCH:   if (i_read) state <= CAPTURE;
        CAPTURE: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a 256-word aliasing memory model.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_active;
  logic [15:0] d_bus;
  logic        i_read, i_push;
  logic [15:0] i_addr;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        inst_valid, inst_ready;
  logic [15:0] inst, inst_pc;

  logic        w_i_read, w_i_push, w_inst_valid;
  logic [15:0] w_d_bus, w_i_addr, w_inst, w_inst_pc;

  logic [15:0] mem [256];
  logic [15:0] m_store, w_store;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .d_active(d_active), .d_bus(d_bus),
    .i_read(i_read), .i_push(i_push), .i_addr(i_addr),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .d_active(1'b0), .d_bus(w_d_bus),
    .i_read(w_i_read), .i_push(w_i_push), .i_addr(w_i_addr),
    .redirect(1'b0), .redirect_addr(16'h0000),
    .inst_valid(w_inst_valid), .inst_ready(1'b1),
    .inst(w_inst), .inst_pc(w_inst_pc)
  );

  // Memory model: registered read, word driven onto the bus during push.
  always @(posedge clk) begin
    if (i_read)   m_store <= mem[i_addr[7:0]];
    if (w_i_read) w_store <= mem[w_i_addr[7:0]];
  end
  assign d_bus   = i_push   ? m_store : 16'hDEAD;
  assign w_d_bus = w_i_push ? w_store : 16'hDEAD;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] w, input logic [15:0] p);
    exp_t e;
    e.word = w;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h/%h required=none", inst, inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", inst, e.word);
        chk("sb_inst_pc", inst_pc, e.pc);
      end
    end
  end

  initial begin
    logic ird  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic ipsh [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic ival [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] iad [7] = '{16'h0, 16'h0, 16'h1, 16'h1, 16'h2, 16'h2, 16'h3};

    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA500;
    mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222; mem[8'h02] = 16'h3333;
    mem[8'h03] = 16'h4444; mem[8'h04] = 16'h5555; mem[8'h10] = 16'hABCD;
    mem[8'h11] = 16'h1234; mem[8'hFF] = 16'hF00F;

    rst_n = 1'b0; d_active = 1'b0; redirect = 1'b0;
    redirect_addr = 16'h0000; inst_ready = 1'b1;

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    chk("rst_i_read", 16'(i_read), 16'h0);
    chk("rst_i_push", 16'(i_push), 16'h0);
    chk("rst_valid", 16'(inst_valid), 16'h0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    chk("rst_i_addr", i_addr, 16'h0000);

    // Stream three words with decode always ready
    expect_word(16'h1111, 16'h0000);
    expect_word(16'h2222, 16'h0001);
    expect_word(16'h3333, 16'h0002);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("stream_i_read_c%0d", k), 16'(i_read), 16'(ird[k]));
      chk($sformatf("stream_i_push_c%0d", k), 16'(i_push), 16'(ipsh[k]));
      chk($sformatf("stream_valid_c%0d", k), 16'(inst_valid), 16'(ival[k]));
      chk($sformatf("stream_i_addr_c%0d", k), i_addr, iad[k]);
      if (k == 2) begin
        chk("wrap_valid", 16'(w_inst_valid), 16'h1);
        chk("wrap_inst", w_inst, 16'hF00F);
        chk("wrap_inst_pc", w_inst_pc, 16'hFFFF);
        chk("wrap_i_addr", w_i_addr, 16'h0000);
      end
      cyc();
    end

    // Reset pulled during the push cycle
    inst_ready = 1'b0;
    @(negedge clk);
    chk("midrst_push_before", 16'(i_push), 16'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_push", 16'(i_push), 16'h0);
    chk("midrst_valid", 16'(inst_valid), 16'h0);
    chk("midrst_i_addr", i_addr, 16'h0000);
    chk("midrst_i_read", 16'(i_read), 16'h0);
    cyc(); cyc();
    inst_ready = 1'b1;
    rst_n = 1'b1;

    // c0: first read after release
    @(negedge clk);
    chk("rel_i_read", 16'(i_read), 16'h1);
    chk("rel_i_addr", i_addr, 16'h0000);
    cyc();
    // c1: push, then backpressure
    inst_ready = 1'b0;
    @(negedge clk);
    chk("bp_push", 16'(i_push), 16'h1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", 16'(inst_valid), 16'h1);
      chk("bp_inst", inst, 16'h1111);
      chk("bp_inst_pc", inst_pc, 16'h0000);
      chk("bp_i_read", 16'(i_read), 16'h0);
      cyc();
    end
    // c6: release backpressure, read issues same cycle
    inst_ready = 1'b1;
    expect_word(16'h1111, 16'h0000);
    @(negedge clk);
    chk("bp_rel_i_read", 16'(i_read), 16'h1);
    chk("bp_rel_i_addr", i_addr, 16'h0001);
    cyc();
    // c7: push 2222
    inst_ready = 1'b0;
    expect_word(16'h2222, 16'h0001);
    @(negedge clk);
    chk("c7_push", 16'(i_push), 16'h1);
    cyc();
    // c8..c10: data side owns memory
    inst_ready = 1'b1;
    d_active = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dprio_i_read", 16'(i_read), 16'h0);
      chk("dprio_i_addr", i_addr, 16'h0002);
      cyc();
    end
    // c11: data side releases
    d_active = 1'b0;
    expect_word(16'h3333, 16'h0002);
    expect_word(16'h4444, 16'h0003);
    expect_word(16'h5555, 16'h0004);
    @(negedge clk);
    chk("dprio_rel_i_read", 16'(i_read), 16'h1);
    chk("dprio_rel_i_addr", i_addr, 16'h0002);
    cyc();
    repeat (5) cyc();
    // c17: read at PC=5
    @(negedge clk);
    chk("redir_pre_i_read", 16'(i_read), 16'h1);
    chk("redir_pre_i_addr", i_addr, 16'h0005);
    cyc();
    // c18: redirect in the push cycle
    redirect = 1'b1;
    redirect_addr = 16'h0010;
    @(negedge clk);
    chk("redir_i_push", 16'(i_push), 16'h0);
    chk("redir_i_read", 16'(i_read), 16'h0);
    cyc();
    // c19: read from new target
    redirect = 1'b0;
    expect_word(16'hABCD, 16'h0010);
    @(negedge clk);
    chk("redir_post_valid", 16'(inst_valid), 16'h0);
    chk("redir_post_i_read", 16'(i_read), 16'h1);
    chk("redir_post_i_addr", i_addr, 16'h0010);
    cyc();
    @(negedge clk);
    chk("redir_post_push", 16'(i_push), 16'h1);
    cyc();
    cyc();
    // c22: hold next word
    inst_ready = 1'b0;
    cyc();
    // c23: redirect together with ready: flush wins
    redirect = 1'b1;
    redirect_addr = 16'h0020;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("flush_pre_valid", 16'(inst_valid), 16'h1);
    chk("flush_pre_inst", inst, 16'h1234);
    cyc();
    redirect = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    chk("flush_valid", 16'(inst_valid), 16'h0);
    chk("flush_i_read", 16'(i_read), 16'h1);
    chk("flush_i_addr", i_addr, 16'h0020);
    repeat (4) cyc();

    chk("sb_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
